// File: rtl/sound_sequencer_pkg.sv
// Shared types, constants and melody contents for the sound sequencer.
// Contents: state enum, note constants (chromatic do..si, rest), note record,
// melody lookup function and the lowest-set-bit arbiter helper.
package sound_sequencer_pkg;

    localparam int unsigned NUM_REQ    = 3;
    localparam int unsigned NOTE_IDX_W = 3;
    localparam int unsigned DUR_W      = 8;
    localparam int unsigned GAP_TICKS  = 1;
    localparam int unsigned ID_W       = 2;
    localparam int unsigned TONE_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP
    } state_t;

    typedef logic [TONE_W-1:0]     tone_t;
    typedef logic [ID_W-1:0]       melody_id_t;
    typedef logic [NOTE_IDX_W-1:0] note_idx_t;
    typedef logic [DUR_W-1:0]      dur_t;

    localparam tone_t NOTE_DO    = 4'd0;
    localparam tone_t NOTE_DOS   = 4'd1;
    localparam tone_t NOTE_RE    = 4'd2;
    localparam tone_t NOTE_RES   = 4'd3;
    localparam tone_t NOTE_MI    = 4'd4;
    localparam tone_t NOTE_FA    = 4'd5;
    localparam tone_t NOTE_FAS   = 4'd6;
    localparam tone_t NOTE_SOL   = 4'd7;
    localparam tone_t NOTE_SOLS  = 4'd8;
    localparam tone_t NOTE_LA    = 4'd9;
    localparam tone_t NOTE_LAS   = 4'd10;
    localparam tone_t NOTE_SI    = 4'd11;
    localparam tone_t NOTE_LIMIT = 4'd12;
    localparam tone_t NOTE_REST  = 4'hF;

    typedef struct packed {
        tone_t tone;
        dur_t  dur;
        logic  last;
    } note_t;

    function automatic note_t mk_note(input tone_t tone, input dur_t dur, input logic last);
        mk_note.tone = tone;
        mk_note.dur  = dur;
        mk_note.last = last;
    endfunction

    // Unused slots return a terminating rest so a bad index can never run away.
    function automatic note_t melody_lookup(input melody_id_t id, input note_idx_t idx);
        melody_lookup = mk_note(NOTE_REST, 8'd1, 1'b1);
        case (id)
            2'd0: begin
                case (idx)
                    3'd0:    melody_lookup = mk_note(NOTE_DO,  8'd4, 1'b0);
                    3'd1:    melody_lookup = mk_note(NOTE_MI,  8'd4, 1'b0);
                    3'd2:    melody_lookup = mk_note(NOTE_SOL, 8'd8, 1'b1);
                    default: ;
                endcase
            end
            2'd1: begin
                case (idx)
                    3'd0:    melody_lookup = mk_note(NOTE_LA, 8'd2, 1'b1);
                    default: ;
                endcase
            end
            2'd2: begin
                case (idx)
                    3'd0:    melody_lookup = mk_note(NOTE_SI,   8'd1, 1'b0);
                    3'd1:    melody_lookup = mk_note(NOTE_REST, 8'd1, 1'b0);
                    3'd2:    melody_lookup = mk_note(NOTE_SI,   8'd1, 1'b1);
                    default: ;
                endcase
            end
            default: ;
        endcase
    endfunction

    // Index of the lowest set bit (highest priority); 0 when none set.
    function automatic melody_id_t lowest_idx(input logic [NUM_REQ-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Game-logic <-> sound sequencer bus.
// master: game side (drives req, tick; observes tone, sound_en, busy, active_id, done)
// slave : sequencer side (the reverse).
interface sound_sequencer_if;
    import sound_sequencer_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               tick;
    tone_t              tone;
    logic               sound_en;
    logic               busy;
    melody_id_t         active_id;
    logic               done;

    modport master (output req, tick, input tone, sound_en, busy, active_id, done);
    modport slave  (input req, tick, output tone, sound_en, busy, active_id, done);
endinterface

// File: rtl/sound_sequencer_melody_rom.sv
// Combinational melody ROM: (melody id, note index) -> note record.
// Ports: id, idx in; entry_c out (combinational).
module melody_rom
    import sound_sequencer_pkg::*;
(
    input  melody_id_t id,
    input  note_idx_t  idx,
    output note_t      entry_c
);
    always_comb entry_c = melody_lookup(id, idx);
endmodule

// File: rtl/sound_sequencer.sv
// Sound-effect sequencer: fixed-priority arbitration of one-shot requests,
// note-by-note melody playback from the ROM, note/gap timing in external ticks.
// Ports: clk, reset (async, active-high); bus (slave): req, tick in;
// tone, sound_en, busy, active_id, done out (all registered).
// Optional: define SOUND_SEQ_QUEUE_EN to keep one pending flag per requester.
module sound_sequencer
    import sound_sequencer_pkg::*;
(
    input logic              clk,
    input logic              reset,
    sound_sequencer_if.slave bus
);

    state_t     state_q, state_d;
    note_idx_t  note_idx_q, note_idx_d;
    dur_t       cnt_q, cnt_d;
    melody_id_t id_q, id_d;
    tone_t      tone_q, tone_d;
    logic       last_q, last_d;
    logic       sound_en_q, sound_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    note_t      rom_entry;
    melody_id_t win_id;
    melody_id_t start_id;
    logic       accept;
    logic       start;
    logic       finish;
    logic       next_note;
`ifdef SOUND_SEQ_QUEUE_EN
    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [NUM_REQ-1:0] win_mask;
`endif

    melody_rom u_rom (
        .id      (id_q),
        .idx     (note_idx_q),
        .entry_c (rom_entry)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        note_idx_d = note_idx_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        tone_d     = tone_q;
        last_d     = last_q;
        sound_en_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        finish     = 1'b0;
        next_note  = 1'b0;
        win_id     = lowest_idx(bus.req);
        // Starting from idle, or a strictly higher-priority requester preempts.
        accept     = (|bus.req) && ((state_q == ST_IDLE) || (win_id < id_q));
        start      = accept;
        start_id   = win_id;
`ifdef SOUND_SEQ_QUEUE_EN
        pend_d     = pend_q;
        win_mask   = accept ? (NUM_REQ'(1) << win_id) : '0;
`endif

        case (state_q)
            ST_LOAD: begin
                tone_d  = rom_entry.tone;
                last_d  = rom_entry.last;
                cnt_d   = (rom_entry.dur == '0) ? DUR_W'(1) : rom_entry.dur;
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.tick) begin
                    if (cnt_q == DUR_W'(1)) begin
                        if (GAP_TICKS != 0) begin
                            state_d = ST_GAP;
                            cnt_d   = DUR_W'(GAP_TICKS);
                        end else if (last_q) begin
                            finish = 1'b1;
                        end else begin
                            next_note = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (bus.tick) begin
                    if (cnt_q == DUR_W'(1)) begin
                        if (last_q) finish = 1'b1;
                        else        next_note = 1'b1;
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if (finish) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end
        if (next_note) begin
            state_d    = ST_LOAD;
            note_idx_d = note_idx_q + NOTE_IDX_W'(1);
        end

`ifdef SOUND_SEQ_QUEUE_EN
        // Requests not taken while busy are remembered; completion pops the lowest.
        if (state_q != ST_IDLE) pend_d = pend_q | (bus.req & ~win_mask);
        if (!accept && finish && (pend_d != '0)) begin
            start    = 1'b1;
            start_id = lowest_idx(pend_d);
            pend_d   = pend_d & ~(NUM_REQ'(1) << lowest_idx(pend_d));
        end
`endif

        // A started melody overrides any tick processing this cycle; done is kept.
        if (start) begin
            state_d    = ST_LOAD;
            note_idx_d = '0;
            id_d       = start_id;
            cnt_d      = cnt_q;
            tone_d     = tone_q;
            last_d     = last_q;
        end

        busy_d     = (state_d != ST_IDLE);
        sound_en_d = (state_d == ST_PLAY) && (tone_d < NOTE_LIMIT);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            note_idx_q <= '0;
            cnt_q      <= '0;
            id_q       <= '0;
            tone_q     <= '0;
            last_q     <= 1'b0;
            sound_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SOUND_SEQ_QUEUE_EN
            pend_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            note_idx_q <= note_idx_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            tone_q     <= tone_d;
            last_q     <= last_d;
            sound_en_q <= sound_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SOUND_SEQ_QUEUE_EN
            pend_q     <= pend_d;
`endif
        end
    end

    assign bus.tone      = tone_q;
    assign bus.sound_en  = sound_en_q;
    assign bus.busy      = busy_q;
    assign bus.active_id = id_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer. Expected per-tick tone/enable
// pairs are queued when a melody is requested and popped once per tick period.
module tb_sound_sequencer;

    localparam int GAP = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sound_sequencer_if bus();

    sound_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] tone;
        logic       en;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   exp_done = 0;

    always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [2:0] r);
        bus.req = r;
        clk1();
        bus.req = '0;
    endtask

    task automatic push_note(input logic [3:0] t, input int dur);
        for (int k = 0; k < dur; k++) sb.push_back('{tone: t, en: (t < 4'd12)});
        for (int k = 0; k < GAP; k++) sb.push_back('{tone: t, en: 1'b0});
    endtask

    task automatic push_melody(input int id);
        case (id)
            0: begin
                push_note(4'd0, 4);
                push_note(4'd4, 4);
                push_note(4'd7, 8);
            end
            1: push_note(4'd9, 2);
            default: begin
                push_note(4'd11, 1);
                push_note(4'hF, 1);
                push_note(4'd11, 1);
            end
        endcase
    endtask

    // Sample mid-period, then pulse tick at the end of a 10-clock period.
    task automatic sample_period();
        exp_t e;
        repeat (5) clk1();
        e = sb.pop_front();
        check("tone", 32'(bus.tone), 32'(e.tone));
        check("sound_en", 32'(bus.sound_en), 32'(e.en));
        check("busy_play", 32'(bus.busy), 32'd1);
        repeat (4) clk1();
    endtask

    task automatic play_out(input int keep);
        while (sb.size() > keep) begin
            sample_period();
            bus.tick = 1'b1;
            clk1();
            bus.tick = 1'b0;
        end
    endtask

    task automatic check_done(input logic exp_busy);
        exp_done++;
        check("done_pulse", 32'(bus.done), 32'd1);
        check("busy_at_done", 32'(bus.busy), 32'(exp_busy));
        clk1();
        check("done_cleared", 32'(bus.done), 32'd0);
        check("done_count", 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        reset    = 1'b1;
        bus.req  = '0;
        bus.tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tone", 32'(bus.tone), 32'd0);
        check("rst_en", 32'(bus.sound_en), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_id", 32'(bus.active_id), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        clk1();

        // Goal melody from idle: LOAD next cycle, tone valid the cycle after.
        drive_req(3'b001);
        check("load_busy", 32'(bus.busy), 32'd1);
        check("load_id", 32'(bus.active_id), 32'd0);
        check("load_en", 32'(bus.sound_en), 32'd0);
        clk1();
        check("t2_tone", 32'(bus.tone), 32'd0);
        check("t2_en", 32'(bus.sound_en), 32'd1);
        push_melody(0);
        play_out(0);
        check("hold_tone", 32'(bus.tone), 32'd7);
        check_done(1'b0);

        // Wall melody with a rest note.
        drive_req(3'b100);
        clk1();
        check("wall_tone", 32'(bus.tone), 32'd11);
        push_melody(2);
        play_out(0);
        check_done(1'b0);

        // Kick preempted by goal: no done for kick.
        drive_req(3'b010);
        clk1();
        check("kick_tone", 32'(bus.tone), 32'd9);
        check("kick_id", 32'(bus.active_id), 32'd1);
        repeat (3) clk1();
        drive_req(3'b001);
        check("preempt_id", 32'(bus.active_id), 32'd0);
        check("preempt_busy", 32'(bus.busy), 32'd1);
        check("preempt_no_done", 32'(bus.done), 32'd0);
        clk1();
        check("preempt_tone", 32'(bus.tone), 32'd0);
        check("preempt_count", 32'(done_cnt), 32'(exp_done));
        push_melody(0);
        play_out(0);
        check_done(1'b0);

        // Lower-priority kick while goal plays is not taken now.
        drive_req(3'b001);
        clk1();
        drive_req(3'b010);
        check("drop_id", 32'(bus.active_id), 32'd0);
        check("drop_tone", 32'(bus.tone), 32'd0);
        push_melody(0);
        play_out(0);
`ifdef SOUND_SEQ_QUEUE_EN
        check_done(1'b1);
        check("queued_id", 32'(bus.active_id), 32'd1);
        push_melody(1);
        play_out(0);
        check_done(1'b0);
`else
        check_done(1'b0);
        repeat (3) clk1();
        check("drop_idle", 32'(bus.busy), 32'd0);
`endif

        // Asynchronous reset between edges mid-PLAY.
        drive_req(3'b010);
        clk1();
        check("pre_rst_en", 32'(bus.sound_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_tone", 32'(bus.tone), 32'd0);
        check("arst_en", 32'(bus.sound_en), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_id", 32'(bus.active_id), 32'd0);
        #2 reset = 1'b0;
        clk1();
        drive_req(3'b010);
        clk1();
        check("post_rst_tone", 32'(bus.tone), 32'd9);
        check("post_rst_en", 32'(bus.sound_en), 32'd1);
        push_melody(1);
        play_out(0);
        check_done(1'b0);

        // Goal request and tick together on wall's final gap tick.
        drive_req(3'b100);
        clk1();
        push_melody(2);
        play_out(1);
        sample_period();
        bus.tick = 1'b1;
        bus.req  = 3'b001;
        clk1();
        bus.tick = 1'b0;
        bus.req  = '0;
        check("coll_id", 32'(bus.active_id), 32'd0);
        check("coll_tone_hold", 32'(bus.tone), 32'd11);
        check_done(1'b1);
        check("coll_tone", 32'(bus.tone), 32'd0);
        check("coll_en", 32'(bus.sound_en), 32'd1);
        push_melody(0);
        play_out(0);
        check_done(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
